// File: rtl/hci_core_load_streamer.sv
// hci_core_load_streamer: strided wide-read source for an HCI core master port.
// Issues DW-bit read requests and returns the data on a valid/ready stream
// through a small receive FIFO. Credit counting limits the beats that are in
// flight or buffered to the FIFO depth, so a granted read can always be stored.
// Optional stall counter: define HCI_LOAD_STREAMER_PERF_EN.
module hci_core_load_streamer #(
  parameter int unsigned DW         = 64,
  parameter int unsigned AW         = 32,
  parameter int unsigned BW         = 8,
  parameter int unsigned NB_CREDITS = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [AW-1:0]        stride_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  output logic [AW-1:0]        tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [DW/BW-1:0]     tcdm_be_o,
  output logic [DW-1:0]        tcdm_data_o,
  input  logic                 tcdm_gnt_i,
  input  logic                 tcdm_r_valid_i,
  input  logic [DW-1:0]        tcdm_r_data_i,
  output logic                 stream_valid_o,
  output logic [DW-1:0]        stream_data_o,
  output logic [DW/8-1:0]      stream_strb_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          perf_stall_o
);

  localparam int unsigned OFF_W = $clog2(DW/8);
  localparam int unsigned PTR_W = $clog2(NB_CREDITS);
  localparam int unsigned CNT_W = $clog2(NB_CREDITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     addr_reg, stride_reg;
  logic [LEN_W-1:0]  len_reg, issue_reg, issue_inc;
  logic              inflight_reg;
  logic [CNT_W-1:0]  count_reg, count_next, used_credits;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DW-1:0]     fifo_mem [NB_CREDITS];
  logic              done_reg, busy_reg, valid_reg;
  logic              sync_clr, start_acc, grant, last_grant, has_credit;
  logic              push, pop, drain_done;

  assign sync_clr     = rst_i | clear_i;
  assign start_acc    = (state_reg == IDLE) && start_i;
  assign grant        = tcdm_req_o && tcdm_gnt_i;
  assign issue_inc    = issue_reg + LEN_W'(1);
  assign last_grant   = grant && (issue_inc == len_reg);
  // Beats granted but not yet returned plus beats already buffered.
  assign used_credits = CNT_W'(inflight_reg) + count_reg;
  assign has_credit   = used_credits < CNT_W'(NB_CREDITS);
  // Responses are only legal one cycle after a grant; stray ones are dropped.
  assign push         = tcdm_r_valid_i && inflight_reg;
  assign pop          = valid_reg && stream_ready_i;
  // Completion is judged on the post-update FIFO level so done follows the
  // final stream handshake by exactly one cycle.
  assign drain_done   = (state_reg == DRAIN) && !inflight_reg && (count_next == '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (sync_clr) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i && (len_i != '0)) state_next = RUN;
      RUN:     if (last_grant)               state_next = DRAIN;
      DRAIN:   if (drain_done)               state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // Request output: only while running and while a FIFO slot is reserved-free
  always_comb begin
    tcdm_req_o = 1'b0;
    if (state_reg == RUN) tcdm_req_o = has_credit;
  end

  // Transfer descriptor and address generation
  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      addr_reg   <= '0;
      stride_reg <= '0;
      len_reg    <= '0;
      issue_reg  <= '0;
    end else if (start_acc) begin
      addr_reg   <= base_addr_i;
      stride_reg <= stride_i;
      len_reg    <= len_i;
      issue_reg  <= '0;
    end else if (grant) begin
      addr_reg   <= addr_reg + stride_reg;
      issue_reg  <= issue_inc;
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // In-flight flag, FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      valid_reg    <= 1'b0;
    end else begin
      inflight_reg <= grant;
      count_reg    <= count_next;
      valid_reg    <= (count_next != '0);
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(NB_CREDITS - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(NB_CREDITS - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= tcdm_r_data_i;
  end

  // Status flags
  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      done_reg <= (start_acc && (len_i == '0)) || drain_done;
      busy_reg <= (state_next != IDLE);
    end
  end

`ifdef HCI_LOAD_STREAMER_PERF_EN
  logic [31:0] perf_reg;
  logic        stall_cycle;
  assign stall_cycle = (state_reg == RUN) && ((tcdm_req_o && !tcdm_gnt_i) || !has_credit);

  // Saturating stall counter, restarted by every accepted launch
  always_ff @(posedge clk_i) begin
    if (sync_clr || start_acc)              perf_reg <= '0;
    else if (stall_cycle && (perf_reg != '1)) perf_reg <= perf_reg + 32'd1;
  end
  assign perf_stall_o = perf_reg;
`else
  assign perf_stall_o = '0;
`endif

  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign tcdm_add_o     = {addr_reg[AW-1:OFF_W], {OFF_W{1'b0}}};
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = valid_reg;
  assign stream_data_o  = fifo_mem[rd_ptr_reg];
  assign stream_strb_o  = '1;

endmodule

// File: tb/tb_hci_core_load_streamer.sv
// Scoreboard bench for hci_core_load_streamer: expected addresses and data are
// queued at launch; monitors pop and compare on each grant and stream beat.
module tb_hci_core_load_streamer;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int NB = 4;
  localparam int LW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW-1:0]   stride_i = '0;
  logic [LW-1:0]   len_i = '0;
  logic            busy_o, done_o, tcdm_req_o, tcdm_wen_o;
  logic [AW-1:0]   tcdm_add_o;
  logic [DW/BW-1:0] tcdm_be_o;
  logic [DW-1:0]   tcdm_data_o;
  logic            tcdm_gnt_i = 1'b1;
  logic            tcdm_r_valid_i = 1'b0;
  logic [DW-1:0]   tcdm_r_data_i = '0;
  logic            stream_valid_o;
  logic [DW-1:0]   stream_data_o;
  logic [DW/8-1:0] stream_strb_o;
  logic            stream_ready_i = 1'b1;
  logic [31:0]     perf_stall_o;

  always #5 clk_i = ~clk_i;

  hci_core_load_streamer #(.DW(DW), .AW(AW), .BW(BW), .NB_CREDITS(NB), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .stream_valid_o(stream_valid_o), .stream_data_o(stream_data_o),
    .stream_strb_o(stream_strb_o), .stream_ready_i(stream_ready_i),
    .perf_stall_o(perf_stall_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int beat_n = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int grant_cyc_q[$];
  int hs_cyc_q[$];
  logic zero_len_expect = 1'b0;
  logic prev_last_hs = 1'b0;
  logic hold_valid = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic gnt_mode = 1'b0;
  int gcyc = 0;
  logic pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Grant pattern: constant 1, or 1,0,0,1,0,0,...
  always @(posedge clk_i) begin
    #1;
    gcyc++;
    tcdm_gnt_i = gnt_mode ? ((gcyc % 3) == 0) : 1'b1;
  end

  // Memory model: answer every grant exactly one cycle later
  always @(negedge clk_i) begin
    pend      = tcdm_req_o && tcdm_gnt_i;
    pend_addr = tcdm_add_o;
  end
  always @(posedge clk_i) begin
    #1;
    tcdm_r_valid_i = pend;
    tcdm_r_data_i  = pend ? mem_word(pend_addr) : '0;
  end

  // Monitor: request side, stream side and done timing
  always @(negedge clk_i) begin
    if (hold_valid) begin
      check("req_hold", {63'd0, tcdm_req_o}, 64'd1);
      check("addr_hold", {32'd0, tcdm_add_o}, {32'd0, hold_addr});
    end
    hold_valid = tcdm_req_o && !tcdm_gnt_i;
    hold_addr  = tcdm_add_o;
    if (tcdm_req_o && tcdm_gnt_i) begin
      grant_cnt++;
      grant_cyc_q.push_back(cyc);
      check("req_fields", {tcdm_wen_o, tcdm_be_o, tcdm_data_o[54:0]}, {1'b1, 8'hFF, 55'd0});
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_grant: got addr %h, expected no request", tcdm_add_o);
      end else begin
        check("grant_addr", {32'd0, tcdm_add_o}, {32'd0, exp_addr_q.pop_front()});
      end
    end
    if (done_o) begin
      done_cnt++;
      if (!zero_len_expect) check("done_after_last_beat", {63'd0, prev_last_hs}, 64'd1);
    end
    if (stream_valid_o && stream_ready_i) begin
      hs_cyc_q.push_back(cyc);
      check("stream_strb", {56'd0, stream_strb_o}, 64'hFF);
      if (exp_data_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got data %h, expected no beat", stream_data_o);
      end else begin
        check("stream_data", stream_data_o, exp_data_q.pop_front());
      end
      beat_n++;
      $display("beat %0d: data=%h cycle=%0d", beat_n, stream_data_o, cyc);
      prev_last_hs = (exp_data_q.size() == 0);
    end else begin
      prev_last_hs = 1'b0;
    end
  end

  // Queue the expected beats and pulse start for one cycle
  task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] stride, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    logic [AW-1:0] al;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      al = {a[AW-1:3], 3'b000};
      exp_addr_q.push_back(al);
      exp_data_q.push_back(mem_word(al));
      a = a + stride;
    end
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = base; stride_i = stride; len_i = len;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk_i);
      if (done_o) break;
      k++;
    end
    n_cmp++;
    if (!done_o) begin
      n_err++;
      $display("FAIL %s: done_o got 0 within %0d cycles, expected 1", name, budget);
    end
    check({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
    check({name, "_data_q_empty"}, 64'(exp_data_q.size()), 64'd0);
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"},  {63'd0, busy_o}, 64'd0);
    check({name, "_done"},  {63'd0, done_o}, 64'd0);
    check({name, "_req"},   {63'd0, tcdm_req_o}, 64'd0);
    check({name, "_valid"}, {63'd0, stream_valid_o}, 64'd0);
    check({name, "_add"},   {32'd0, tcdm_add_o}, 64'd0);
    check({name, "_perf"},  {32'd0, perf_stall_o}, 64'd0);
  endtask

  initial begin
    int g0;
    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Basic run: latency, ordering and 1 beat/cycle
    grant_cyc_q.delete(); hs_cyc_q.delete();
    launch(32'h100, 32'd8, 16'd4);
    @(negedge clk_i);
    check("first_req_latency", {63'd0, tcdm_req_o}, 64'd1);
    check("busy_running", {63'd0, busy_o}, 64'd1);
    @(negedge clk_i);
    check("valid_not_early", {63'd0, stream_valid_o}, 64'd0);
    @(negedge clk_i);
    check("valid_latency", {63'd0, stream_valid_o}, 64'd1);
    wait_done("basic", 20);
    if (grant_cyc_q.size() == 4 && hs_cyc_q.size() == 4) begin
      check("basic_grant_span", 64'(grant_cyc_q[3] - grant_cyc_q[0]), 64'd3);
      check("basic_beat_span", 64'(hs_cyc_q[3] - hs_cyc_q[0]), 64'd3);
    end else begin
      check("basic_counts", 64'(grant_cyc_q.size() * 16 + hs_cyc_q.size()), 64'(4 * 16 + 4));
    end
    @(negedge clk_i);
    check("basic_idle_busy", {63'd0, busy_o}, 64'd0);

    // Backpressure: credits cap in-flight beats; a start while running is ignored
    @(posedge clk_i); #1;
    stream_ready_i = 1'b0;
    g0 = grant_cnt;
    launch(32'h2000, 32'h40, 16'd10);
    repeat (6) @(negedge clk_i);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = 32'h9000; stride_i = 32'd8; len_i = 16'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (16) @(negedge clk_i);
    check("bp_grants", 64'(grant_cnt - g0), 64'(NB));
    check("bp_req_low", {63'd0, tcdm_req_o}, 64'd0);
    check("bp_valid_held", {63'd0, stream_valid_o}, 64'd1);
`ifdef HCI_LOAD_STREAMER_PERF_EN
    check("bp_perf_min", {63'd0, (perf_stall_o >= 32'd16)}, 64'd1);
`endif
    @(posedge clk_i); #1;
    stream_ready_i = 1'b1;
    wait_done("backpressure", 60);

    // Grant stalls with misaligned base/stride (low bits dropped)
    @(posedge clk_i); #1;
    gnt_mode = 1'b1;
    launch(32'h403, 32'h0C, 16'd6);
    wait_done("gnt_stall", 60);
    @(posedge clk_i); #1;
    gnt_mode = 1'b0;

    // Zero length: done next cycle, no request
    zero_len_expect = 1'b1;
    launch(32'h700, 32'd8, 16'd0);
    @(negedge clk_i);
    check("zero_done", {63'd0, done_o}, 64'd1);
    check("zero_busy", {63'd0, busy_o}, 64'd0);
    check("zero_req", {63'd0, tcdm_req_o}, 64'd0);
    @(negedge clk_i);
    check("zero_done_pulse", {63'd0, done_o}, 64'd0);
    check("zero_req_after", {63'd0, tcdm_req_o}, 64'd0);
    zero_len_expect = 1'b0;

    // Address wrap modulo 2^AW
    launch(32'hFFFF_FFF8, 32'd8, 16'd3);
    wait_done("wrap", 20);

    // Reset while one beat is in flight
    exp_addr_q.push_back(32'h3000);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = 32'h3000; stride_i = 32'd8; len_i = 16'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_zero("midreset");
    @(negedge clk_i);
    check("midreset_late_rvalid_dropped", {63'd0, stream_valid_o}, 64'd0);
    check("midreset_addr_q", 64'(exp_addr_q.size()), 64'd0);
    launch(32'h5000, 32'd8, 16'd3);
    wait_done("after_reset", 20);

    @(negedge clk_i);
    check("done_pulse_count", 64'(done_cnt), 64'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
